computer_system_pixel_filter: RTL and testbench

COMPUTER_SYSTEM_PIXEL_FILTER -- requirements
Module: computer_system_pixel_filter

---
 rtl/computer_system_pixel_filter_pkg.sv | 40 ++++
 rtl/computer_system_pixel_gray.sv | 17 +
 rtl/computer_system_pixel_filter.sv | 177 +++++++++++++++++
 tb/tb_computer_system_pixel_filter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/computer_system_pixel_filter_pkg.sv
// Shared definitions for the pixel filter slice.
//   mode_e         : per-beat filter operation (pass / invert / gray / threshold)
//   state_e        : packet-tracking FSM states
//   VIDEO_PKT_TYPE : low nibble of a sop beat that marks a video packet header
//   apply_mode     : RGB 8:8:8 filter kernel used in the mode-apply stage
package computer_system_pixel_filter_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_INV  = 2'd1,
        MODE_GRAY = 2'd2,
        MODE_THR  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        WAIT_SOP = 2'd0,
        VIDEO    = 2'd1,
        CTRL     = 2'd2
    } state_e;

    localparam logic [3:0] VIDEO_PKT_TYPE = 4'h0;

    // Inverting a channel as 255 - c is the same as a bitwise complement.
    function automatic logic [23:0] apply_mode(input mode_e       mode,
                                               input logic [23:0] pix,
                                               input logic [7:0]  gray,
                                               input logic [5:0]  thr);
        logic [23:0] res;
        res = pix;
        case (mode)
            MODE_PASS: res = pix;
            MODE_INV:  res = ~pix;
            MODE_GRAY: res = {gray, gray, gray};
            MODE_THR:  res = (gray >= {thr, 2'b00}) ? 24'hFF_FFFF : 24'h00_0000;
            default:   res = pix;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/computer_system_pixel_gray.sv
// Combinational RGB 8:8:8 to 8-bit luma approximation.
//   rgb  : packed pixel, R in [23:16], G in [15:8], B in [7:0]
//   gray : (R + 2*G + B) >> 2
module computer_system_pixel_gray (
    input  logic [23:0] rgb,
    output logic [7:0]  gray
);

    logic [9:0] sum_s;

    // Worst case 255 + 510 + 255 = 1020 fits in 10 bits, so no overflow.
    always_comb begin
        sum_s = {2'b00, rgb[23:16]} + {1'b0, rgb[15:8], 1'b0} + {2'b00, rgb[7:0]};
        gray  = sum_s[9:2];
    end

endmodule

// File: rtl/computer_system_pixel_filter.sv
// Avalon-ST video pixel filter with a two-stage pipeline.
//   clk, reset_n          : clock, asynchronous active-low reset
//   filter_select[1:0]    : mode, [7:2] threshold level (sampled on video headers)
//   in_*                  : Avalon-ST sink (data, sop, eop, valid, ready)
//   out_*                 : Avalon-ST source (data, sop, eop, valid, ready)
//   active_mode           : mode latched from the most recent video header
// S1 computes gray and tags each beat with the mode to apply; S2 applies it.
// Beats outside a packet are accepted and dropped at S1 entry.
module computer_system_pixel_filter
    import computer_system_pixel_filter_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        filter_select,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_startofpacket,
    input  logic              in_endofpacket,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_startofpacket,
    output logic              out_endofpacket,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        active_mode
);

    state_e            state_r, state_next_s;
    mode_e             mode_r;
    logic [5:0]        thr_r;

    logic              s1_valid_r, s1_sop_r, s1_eop_r;
    logic [DATA_W-1:0] s1_data_r;
    logic [7:0]        s1_gray_r;
    mode_e             s1_mode_r;
    logic [5:0]        s1_thr_r;

    logic              s2_valid_r, s2_sop_r, s2_eop_r;
    logic [DATA_W-1:0] s2_data_r;

    logic              s1_load_s, s2_load_s, in_xfer_s, is_hdr_s;
    logic              keep_s, latch_s;
    mode_e             beat_mode_s;
    logic [7:0]        gray_s;
    logic [DATA_W-1:0] filt_s;

    computer_system_pixel_gray u_gray (
        .rgb  (in_data[23:0]),
        .gray (gray_s)
    );

    // Pipeline handshake: each stage advances when the one after it can take data.
    always_comb begin
        s2_load_s = out_ready | ~s2_valid_r;
        s1_load_s = s2_load_s | ~s1_valid_r;
        in_xfer_s = in_valid & s1_load_s;
        is_hdr_s  = (in_data[3:0] == VIDEO_PKT_TYPE);
    end

    assign in_ready = s1_load_s;

    // Packet FSM: decides per accepted beat whether it is kept and how it is filtered.
    always_comb begin
        state_next_s = state_r;
        keep_s       = 1'b0;
        latch_s      = 1'b0;
        beat_mode_s  = MODE_PASS;
        if (in_xfer_s) begin
            if (in_startofpacket) begin
                // Any sop restarts packet tracking, even without a prior eop.
                keep_s = 1'b1;
                if (is_hdr_s) begin
                    latch_s      = 1'b1;
                    state_next_s = in_endofpacket ? WAIT_SOP : VIDEO;
                end else begin
                    state_next_s = in_endofpacket ? WAIT_SOP : CTRL;
                end
            end else begin
                case (state_r)
                    VIDEO: begin
                        keep_s       = 1'b1;
                        beat_mode_s  = mode_r;
                        state_next_s = in_endofpacket ? WAIT_SOP : VIDEO;
                    end
                    CTRL: begin
                        keep_s       = 1'b1;
                        state_next_s = in_endofpacket ? WAIT_SOP : CTRL;
                    end
                    WAIT_SOP: begin
                        keep_s       = 1'b0;
                        state_next_s = WAIT_SOP;
                    end
                    default: begin
                        keep_s       = 1'b0;
                        state_next_s = WAIT_SOP;
                    end
                endcase
            end
        end else begin
            state_next_s = state_r;
        end
    end

    // FSM state plus mode/threshold latched on each video header.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= WAIT_SOP;
            mode_r  <= MODE_PASS;
            thr_r   <= 6'd0;
        end else begin
            state_r <= state_next_s;
            if (latch_s) begin
                mode_r <= mode_e'(filter_select[1:0]);
                thr_r  <= filter_select[7:2];
            end else begin
                mode_r <= mode_r;
                thr_r  <= thr_r;
            end
        end
    end

    // S1: capture beat, its gray value, and the mode/threshold in force for it.
    // Threshold travels with the beat so a following header cannot retarget it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_r <= 1'b0;
            s1_sop_r   <= 1'b0;
            s1_eop_r   <= 1'b0;
            s1_data_r  <= '0;
            s1_gray_r  <= 8'd0;
            s1_mode_r  <= MODE_PASS;
            s1_thr_r   <= 6'd0;
        end else if (s1_load_s) begin
            s1_valid_r <= keep_s;
            s1_sop_r   <= in_startofpacket;
            s1_eop_r   <= in_endofpacket;
            s1_data_r  <= in_data;
            s1_gray_r  <= gray_s;
            s1_mode_r  <= beat_mode_s;
            s1_thr_r   <= thr_r;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Mode apply on the low 24 bits; any bits above the RGB field pass through.
    always_comb begin
        filt_s        = s1_data_r;
        filt_s[23:0]  = apply_mode(s1_mode_r, s1_data_r[23:0], s1_gray_r, s1_thr_r);
    end

    // S2: registered source outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_r <= 1'b0;
            s2_sop_r   <= 1'b0;
            s2_eop_r   <= 1'b0;
            s2_data_r  <= '0;
        end else if (s2_load_s) begin
            s2_valid_r <= s1_valid_r;
            s2_sop_r   <= s1_sop_r;
            s2_eop_r   <= s1_eop_r;
            s2_data_r  <= filt_s;
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    assign out_valid         = s2_valid_r;
    assign out_startofpacket = s2_sop_r;
    assign out_endofpacket   = s2_eop_r;
    assign out_data          = s2_data_r;
    assign active_mode       = mode_r;

endmodule

// File: tb/tb_computer_system_pixel_filter.sv
// Scoreboard bench for computer_system_pixel_filter: expected beats are
// produced by a bench-side packet model at each sink transfer and compared
// in order against source transfers.
module tb_computer_system_pixel_filter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  filter_select = 8'h00;
    logic [23:0] in_data = 24'h0;
    logic        in_sop = 1'b0, in_eop = 1'b0, in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] out_data;
    logic        out_sop, out_eop, out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  active_mode;

    typedef struct {
        logic [23:0] data;
        logic        sop;
        logic        eop;
        int          cyc;
        logic        lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc_cnt = 0;
    logic rand_ready = 1'b0;
    int   m_state = 0;   // 0 wait-sop, 1 video, 2 control
    int   m_mode = 0;
    int   m_thr = 0;

    computer_system_pixel_filter #(.DATA_W(24)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .filter_select     (filter_select),
        .in_data           (in_data),
        .in_startofpacket  (in_sop),
        .in_endofpacket    (in_eop),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .out_data          (out_data),
        .out_startofpacket (out_sop),
        .out_endofpacket   (out_eop),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .active_mode       (active_mode)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] ref_filter(input int md, input int th, input logic [23:0] p);
        int r, g, b, gy;
        r  = int'(p[23:16]);
        g  = int'(p[15:8]);
        b  = int'(p[7:0]);
        gy = (r + 2 * g + b) / 4;
        case (md)
            1:       return {8'(255 - r), 8'(255 - g), 8'(255 - b)};
            2:       return {8'(gy), 8'(gy), 8'(gy)};
            3:       return (gy >= th * 4) ? 24'hFFFFFF : 24'h000000;
            default: return p;
        endcase
    endfunction

    function automatic void push_exp(input logic [23:0] d, input logic sop, input logic eop);
        exp_t e;
        e.data = d;
        e.sop  = sop;
        e.eop  = eop;
        e.cyc  = cyc_cnt;
        e.lat  = !rand_ready;
        sb_q.push_back(e);
    endfunction

    // Packet model; has_exp lets directed tests supply a hand-computed value.
    function automatic void model_accept(input logic [23:0] d, input logic sop, input logic eop,
                                         input logic has_exp, input logic [23:0] exp);
        if (sop) begin
            push_exp(has_exp ? exp : d, sop, eop);
            if (d[3:0] == 4'h0) begin
                m_mode  = int'(filter_select[1:0]);
                m_thr   = int'(filter_select[7:2]);
                m_state = eop ? 0 : 1;
            end else begin
                m_state = eop ? 0 : 2;
            end
        end else if (m_state == 1) begin
            push_exp(has_exp ? exp : ref_filter(m_mode, m_thr, d), sop, eop);
            if (eop) m_state = 0;
        end else if (m_state == 2) begin
            push_exp(has_exp ? exp : d, sop, eop);
            if (eop) m_state = 0;
        end
    endfunction

    task automatic send_beat(input logic [23:0] d, input logic sop, input logic eop,
                             input logic has_exp, input logic [23:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        in_data  = d;
        in_sop   = sop;
        in_eop   = eop;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            check_val("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            model_accept(d, sop, eop, has_exp, exp);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check_val("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    // Source side: choose out_ready for this cycle, then score any beat that will transfer.
    always @(negedge clk) begin
        exp_t e;
        out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (reset_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_beat_qsize", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_val("out_data", {8'h00, out_data}, {8'h00, e.data});
                check_val("out_sop_eop", {30'd0, out_sop, out_eop}, {30'd0, e.sop, e.eop});
                if (e.lat) check_val("latency", 32'(cyc_cnt - e.cyc), 32'd2);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_active_mode", 32'(active_mode), 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;

        // Invert: header unchanged, pixel inverted, 2-cycle latency
        filter_select = 8'h01;
        send_beat(24'h123450, 1'b1, 1'b0, 1'b1, 24'h123450);
        check_val("mode_after_hdr_inv", 32'(active_mode), 32'd1);
        send_beat(24'h102030, 1'b0, 1'b1, 1'b1, 24'hEFDFCF);
        drain();

        // Gray and threshold
        filter_select = 8'h02;
        send_beat(24'h000000, 1'b1, 1'b0, 1'b1, 24'h000000);
        send_beat(24'h4080C0, 1'b0, 1'b1, 1'b1, 24'h808080);
        filter_select = 8'h43;
        send_beat(24'hABCDE0, 1'b1, 1'b0, 1'b1, 24'hABCDE0);
        check_val("mode_after_hdr_thr", 32'(active_mode), 32'd3);
        send_beat(24'h101010, 1'b0, 1'b0, 1'b1, 24'h000000);
        send_beat(24'h505050, 1'b0, 1'b1, 1'b1, 24'hFFFFFF);
        drain();

        // Mid-packet filter_select change has no effect until next header
        filter_select = 8'h00;
        send_beat(24'h000000, 1'b1, 1'b0, 1'b1, 24'h000000);
        send_beat(24'h112233, 1'b0, 1'b0, 1'b1, 24'h112233);
        filter_select = 8'h01;
        send_beat(24'h445566, 1'b0, 1'b0, 1'b1, 24'h445566);
        send_beat(24'h778899, 1'b0, 1'b1, 1'b1, 24'h778899);
        drain();
        check_val("mode_held_mid_pkt", 32'(active_mode), 32'd0);
        send_beat(24'h000000, 1'b1, 1'b0, 1'b1, 24'h000000);
        check_val("mode_next_hdr", 32'(active_mode), 32'd1);
        send_beat(24'h102030, 1'b0, 1'b1, 1'b1, 24'hEFDFCF);
        drain();

        // Control packet passes bit-exact while mode 1 is latched
        send_beat(24'h00000F, 1'b1, 1'b0, 1'b1, 24'h00000F);
        send_beat(24'hAABBCC, 1'b0, 1'b0, 1'b1, 24'hAABBCC);
        send_beat(24'h112233, 1'b0, 1'b1, 1'b1, 24'h112233);
        // Beat after eop is outside any packet and must vanish
        send_beat(24'h5A5A5A, 1'b0, 1'b0, 1'b0, 24'h0);
        // Single-beat sop+eop header, then a stray beat
        send_beat(24'h000000, 1'b1, 1'b1, 1'b1, 24'h000000);
        send_beat(24'h777777, 1'b0, 1'b1, 1'b0, 24'h0);
        // Missing eop: new header inside a video packet restarts with the new mode
        filter_select = 8'h02;
        send_beat(24'h000000, 1'b1, 1'b0, 1'b1, 24'h000000);
        send_beat(24'h4080C0, 1'b0, 1'b0, 1'b1, 24'h808080);
        filter_select = 8'h01;
        send_beat(24'hFFFFF0, 1'b1, 1'b0, 1'b1, 24'hFFFFF0);
        send_beat(24'h0F0F0F, 1'b0, 1'b1, 1'b1, 24'hF0F0F0);
        drain();

        // Random backpressure over a 64-beat video packet, model-predicted
        rand_ready = 1'b1;
        filter_select = 8'hA3;
        send_beat(24'h000000, 1'b1, 1'b0, 1'b0, 24'h0);
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send_beat(24'($urandom), 1'b0, (i == 63), 1'b0, 24'h0);
        end
        filter_select = 8'h02;
        send_beat(24'h000000, 1'b1, 1'b0, 1'b0, 24'h0);
        for (int i = 0; i < 16; i++) send_beat(24'($urandom), 1'b0, (i == 15), 1'b0, 24'h0);
        drain();
        rand_ready = 1'b0;

        // Reset mid-packet flushes the pipeline
        filter_select = 8'h01;
        send_beat(24'h000000, 1'b1, 1'b0, 1'b1, 24'h000000);
        send_beat(24'h010203, 1'b0, 1'b0, 1'b1, 24'hFEFDFC);
        send_beat(24'h040506, 1'b0, 1'b0, 1'b1, 24'hFBFAF9);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        sb_q.delete();
        m_state = 0;
        m_mode  = 0;
        m_thr   = 0;
        repeat (3) begin
            @(negedge clk);
            #2;
            check_val("rst_mid_out_valid", 32'(out_valid), 32'd0);
            check_val("rst_mid_active_mode", 32'(active_mode), 32'd0);
        end
        reset_n = 1'b1;
        send_beat(24'h999999, 1'b0, 1'b0, 1'b0, 24'h0);
        send_beat(24'h888888, 1'b0, 1'b1, 1'b0, 24'h0);
        send_beat(24'h000000, 1'b1, 1'b0, 1'b1, 24'h000000);
        check_val("mode_after_reset_hdr", 32'(active_mode), 32'd1);
        send_beat(24'h102030, 1'b0, 1'b0, 1'b1, 24'hEFDFCF);
        send_beat(24'h000000, 1'b0, 1'b1, 1'b1, 24'hFFFFFF);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
